// File: rtl/tlc_multiway_timed.sv
`default_nettype none
// ============================================================================
// Module   : tlc_multiway_timed
// Purpose  : N-way traffic light controller. Each direction is served
//            round-robin with timed GREEN, YELLOW and ALLRED phases.
//            Emergency requests can hold the current green or truncate it,
//            and they redirect service to the lowest-index requesting
//            direction.
// Ports    : clk            - system clock, rising edge
//            rst_n          - asynchronous active-low reset
//            emergency      - per-direction emergency request (level)
//            lights         - 2-bit code per direction (0=RED 1=YELLOW 2=GREEN)
//            active_dir     - direction owning the current phase
//            phase          - 0=GREEN 1=YELLOW 2=ALLRED 3=WALK
//            preempt_active - current direction was chosen by emergency
//            ped_req        - pedestrian request (TLC_PED_EN only)
//            walk           - pedestrian walk signal (TLC_PED_EN only)
// Options  : TLC_PED_EN - builds the pedestrian latch and the WALK phase
// Revision : 1.0 - initial release
// ============================================================================
module tlc_multiway_timed #(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 6,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DIR-1:0]         emergency,
  output logic [2*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [1:0]                 phase,
  output logic                       preempt_active
`ifdef TLC_PED_EN
  ,
  input  logic                       ped_req,
  output logic                       walk
`endif
);

  localparam int DIR_W = $clog2(NUM_DIR);

  localparam logic [1:0] c_code_red    = 2'd0;
  localparam logic [1:0] c_code_yellow = 2'd1;
  localparam logic [1:0] c_code_green  = 2'd2;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_WALK   = 2'd3
  } phase_t;

  phase_t           r_phase;
  logic [DIR_W-1:0] r_dir;
  logic [CNT_W-1:0] r_timer;
  logic             r_preempt;

  logic [DIR_W-1:0] w_emg_dir;
  logic [DIR_W-1:0] w_rr_dir;
  logic             w_emg_any;
  logic             w_timer_zero;
  logic [1:0]       w_code;

`ifdef TLC_PED_EN
  logic             r_ped_latch;
`endif

  // Timer reload value for the phase being entered (duration minus one).
  function automatic logic [CNT_W-1:0] f_load(input phase_t p);
    case (p)
      PH_GREEN:  f_load = CNT_W'(GREEN_CYC - 1);
      PH_YELLOW: f_load = CNT_W'(YELLOW_CYC - 1);
      PH_ALLRED: f_load = CNT_W'(ALLRED_CYC - 1);
      default:   f_load = CNT_W'(WALK_CYC - 1);
    endcase
  endfunction

  // Fixed-priority encoder: lowest-index active emergency wins.
  always_comb begin
    w_emg_dir = '0;
    for (int d = NUM_DIR - 1; d >= 0; d--) begin
      if (emergency[d]) w_emg_dir = DIR_W'(d);
    end
  end

  assign w_emg_any    = |emergency;
  assign w_timer_zero = (r_timer == '0);
  assign w_rr_dir     = (r_dir == DIR_W'(NUM_DIR - 1)) ? '0 : r_dir + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= PH_GREEN;
      r_dir       <= '0;
      r_timer     <= f_load(PH_GREEN);
      r_preempt   <= 1'b0;
`ifdef TLC_PED_EN
      r_ped_latch <= 1'b0;
`endif
    end else begin
`ifdef TLC_PED_EN
      // Sticky request; cleared below when WALK is entered.
      if (ped_req) r_ped_latch <= 1'b1;
`endif
      case (r_phase)
        PH_GREEN: begin
          if (w_emg_any && (w_emg_dir != r_dir)) begin
            // Emergency elsewhere: cut the green short.
            r_phase <= PH_YELLOW;
            r_timer <= f_load(PH_YELLOW);
          end else if (w_emg_any) begin
            // Emergency on our own direction: hold green, timer parks at 0.
            if (!w_timer_zero) r_timer <= r_timer - 1'b1;
          end else if (w_timer_zero) begin
            r_phase <= PH_YELLOW;
            r_timer <= f_load(PH_YELLOW);
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        PH_YELLOW: begin
          if (w_timer_zero) begin
            r_phase <= PH_ALLRED;
            r_timer <= f_load(PH_ALLRED);
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        PH_ALLRED: begin
          if (w_timer_zero) begin
            if (w_emg_any) begin
              r_phase   <= PH_GREEN;
              r_dir     <= w_emg_dir;
              r_preempt <= 1'b1;
              r_timer   <= f_load(PH_GREEN);
`ifdef TLC_PED_EN
            end else if (r_ped_latch) begin
              // Direction is kept so the next green follows round-robin order.
              r_phase     <= PH_WALK;
              r_preempt   <= 1'b0;
              r_ped_latch <= 1'b0;
              r_timer     <= f_load(PH_WALK);
`endif
            end else begin
              r_phase   <= PH_GREEN;
              r_dir     <= w_rr_dir;
              r_preempt <= 1'b0;
              r_timer   <= f_load(PH_GREEN);
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
`ifdef TLC_PED_EN
        PH_WALK: begin
          if (w_emg_any) begin
            r_phase   <= PH_GREEN;
            r_dir     <= w_emg_dir;
            r_preempt <= 1'b1;
            r_timer   <= f_load(PH_GREEN);
          end else if (w_timer_zero) begin
            r_phase <= PH_GREEN;
            r_dir   <= w_rr_dir;
            r_timer <= f_load(PH_GREEN);
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
`endif
        default: begin
          r_phase   <= PH_GREEN;
          r_dir     <= '0;
          r_preempt <= 1'b0;
          r_timer   <= f_load(PH_GREEN);
        end
      endcase
    end
  end

  // Output decode straight from registered state.
  assign w_code = (r_phase == PH_GREEN)  ? c_code_green  :
                  (r_phase == PH_YELLOW) ? c_code_yellow : c_code_red;

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_lights
    assign lights[2*d +: 2] = (r_dir == DIR_W'(d)) ? w_code : c_code_red;
  end

  assign active_dir     = r_dir;
  assign phase          = r_phase;
  assign preempt_active = r_preempt;
`ifdef TLC_PED_EN
  assign walk           = (r_phase == PH_WALK);
`endif

endmodule
`default_nettype wire
